// File: rtl/audio_pkg.sv
// Shared constants and sample type for the I2S audio output path.
package audio_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned SAMPLE_W   = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Small first-word-fall-through sample FIFO; dout always shows the head entry.
module sample_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/audio_dac_tx.sv
// I2S DAC transmitter: buffers mono samples and plays each one on both
// channels of a 64-bit frame, MSB first with the one-bit I2S delay.
module audio_dac_tx #(
  parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned HALF     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       aud_write,
  input  logic signed [SAMPLE_W-1:0] aud_write_d,
  output logic                       aud_write_ready,
  output logic                       dac_bclk,
  output logic                       dac_lrck,
  output logic                       dac_data,
  output logic                       underflow
);

  import audio_pkg::*;

  localparam int unsigned DIV_W = $clog2(HALF);
  localparam int unsigned CNT_W = $clog2(FRAME_BITS);
  localparam int unsigned POS_W = $clog2(SLOT_BITS);
  localparam int unsigned PAD_W = SLOT_BITS - 1 - SAMPLE_W;

  logic [DIV_W-1:0]           div_q, div_d;
  logic                       bclk_q, bclk_d;
  logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       lrck_q, lrck_d;
  logic                       data_q, data_d;
  logic                       underflow_q, underflow_d;

  logic                       bclk_edge_c;
  logic                       fall_c;
  logic                       frame_start_c;
  logic [POS_W-1:0]           pos_c;
  logic [SLOT_BITS-1:0]       slot_c;
  logic                       fifo_push_c;
  logic                       fifo_pop_c;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [SAMPLE_W-1:0]        fifo_dout;

  assign aud_write_ready = reset && !fifo_full;
  assign fifo_push_c     = aud_write && aud_write_ready;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push_c),
    .pop   (fifo_pop_c),
    .din   (aud_write_d),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Bit-clock divider, frame position and serial mux; outputs move only on BCLK falls.
  always_comb begin
    div_d         = div_q;
    bclk_d        = bclk_q;
    bit_cnt_d     = bit_cnt_q;
    sample_d      = sample_q;
    lrck_d        = lrck_q;
    data_d        = data_q;
    underflow_d   = 1'b0;
    fifo_pop_c    = 1'b0;
    pos_c         = '0;
    slot_c        = '0;

    bclk_edge_c   = (div_q == DIV_W'(HALF - 1));
    fall_c        = bclk_edge_c && bclk_q;
    frame_start_c = fall_c && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));

    div_d = bclk_edge_c ? '0 : div_q + DIV_W'(1);
    if (bclk_edge_c) bclk_d = !bclk_q;

    // Slot position 0 always carries 0, so reloading sample_q here is safe.
    if (frame_start_c) begin
      fifo_pop_c  = !fifo_empty;
      underflow_d = fifo_empty;
      sample_d    = fifo_empty ? '0 : $signed(fifo_dout);
    end

    if (fall_c) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      pos_c     = bit_cnt_d[POS_W-1:0];
      slot_c    = SLOT_BITS'(unsigned'(sample_q)) << PAD_W;
      lrck_d    = bit_cnt_d[CNT_W-1];
      data_d    = slot_c[POS_W'(SLOT_BITS - 1) - pos_c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= '0;
      sample_q    <= '0;
      lrck_q      <= 1'b0;
      data_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      sample_q    <= sample_d;
      lrck_q      <= lrck_d;
      data_q      <= data_d;
      underflow_q <= underflow_d;
    end
  end

  assign dac_bclk  = bclk_q;
  assign dac_lrck  = lrck_q;
  assign dac_data  = data_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx: a sample queue predicts every frame's
// content, underflow and write-ready, compared cycle by cycle.
module tb_audio_dac_tx;

  import audio_pkg::*;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned HALF       = 8;
  localparam int          FRAME_CLKS = 2 * HALF * FRAME_BITS;

  logic    clk = 1'b0;
  logic    reset;
  logic    aud_write;
  sample_t aud_write_d;
  logic    aud_write_ready;
  logic    dac_bclk;
  logic    dac_lrck;
  logic    dac_data;
  logic    underflow;

  audio_dac_tx #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .HALF     (HALF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .aud_write       (aud_write),
    .aud_write_d     (aud_write_d),
    .aud_write_ready (aud_write_ready),
    .dac_bclk        (dac_bclk),
    .dac_lrck        (dac_lrck),
    .dac_data        (dac_data),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  int          n_checks    = 0;
  int          n_errors    = 0;
  int          cyc         = 0;
  int          rel_cyc     = 0;
  int          last_toggle = 0;
  int          last_start  = -1;
  int          n_starts    = 0;
  int          falls       = 0;
  int          ready_hi    = 0;
  int          tgt         = 0;
  logic        prev_bclk   = 1'b0;
  logic        prev_lrck   = 1'b0;
  logic [63:0] fbits       = '0;
  logic [63:0] lbits       = '0;
  sample_t     cur         = '0;
  sample_t     exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Left and right slots: one delay bit, the sample MSB first, then zero padding.
  function automatic logic [63:0] frame_word(input sample_t s);
    logic [31:0] slot;
    slot = {1'b0, s, 7'b0};
    return {slot, slot};
  endfunction

  task automatic tick();
    int   pre_size;
    logic acc;
    logic fall;
    logic start;
    pre_size = exp_q.size();
    acc      = aud_write && reset && (pre_size < int'(DEPTH));
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      falls      = 0;
      last_start = -1;
      prev_bclk  = 1'b0;
      prev_lrck  = 1'b0;
      return;
    end
    fall  = prev_bclk && !dac_bclk;
    start = prev_lrck && !dac_lrck;
    if (dac_bclk !== prev_bclk) begin
      check("bclk_half", 64'(cyc - last_toggle), 64'(HALF));
      last_toggle = cyc;
    end
    if (start) begin
      if (falls == 64) begin
        check("frame_data", fbits, frame_word(cur));
        check("frame_lrck", lbits, {32'h0, 32'hFFFF_FFFF});
      end
      if (last_start < 0) check("first_frame", 64'(cyc - rel_cyc), 64'(FRAME_CLKS));
      else                check("frame_period", 64'(cyc - last_start), 64'(FRAME_CLKS));
      last_start = cyc;
      n_starts++;
      check("underflow", 64'(underflow), 64'(exp_q.size() == 0));
      if (exp_q.size() == 0) cur = '0;
      else                   cur = exp_q.pop_front();
      falls = 0;
      fbits = '0;
      lbits = '0;
    end else begin
      check("uf_idle", 64'(underflow), 64'(0));
    end
    if (fall) begin
      fbits = {fbits[62:0], dac_data};
      lbits = {lbits[62:0], dac_lrck};
      falls++;
    end
    if (acc) exp_q.push_back(aud_write_d);
    check("ready", 64'(aud_write_ready), 64'(exp_q.size() < int'(DEPTH)));
    prev_bclk = dac_bclk;
    prev_lrck = dac_lrck;
  endtask

  task automatic release_reset();
    reset       = 1'b1;
    rel_cyc     = cyc;
    last_toggle = cyc;
    last_start  = -1;
  endtask

  task automatic wait_frames(input int n);
    int goal;
    goal = n_starts + n;
    for (int i = 0; i < n * (FRAME_CLKS + 64); i++) begin
      if (n_starts >= goal) break;
      tick();
    end
    check("wait_frames", 64'(n_starts), 64'(goal));
  endtask

  task automatic push_one(input sample_t v);
    aud_write   = 1'b1;
    aud_write_d = v;
    tick();
    aud_write   = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    aud_write   = 1'b0;
    aud_write_d = '0;
    repeat (4) tick();
    check("rst_outputs", 64'({aud_write_ready, dac_bclk, dac_lrck, dac_data, underflow}), 64'(0));
    release_reset();
    tick();
    check("ready_after_release", 64'(aud_write_ready), 64'(1));

    // Empty FIFO: underflow at every frame start, silent frames.
    wait_frames(4);

    push_one(sample_t'(32'h00A5_F00F));
    wait_frames(2);

    // Nine back-to-back writes: eight stored, ninth dropped.
    for (int i = 0; i < 9; i++) begin
      aud_write   = 1'b1;
      aud_write_d = sample_t'(32'h0011_1111 * (i + 1));
      tick();
      if (i == 7) check("ready_full", 64'(aud_write_ready), 64'(0));
    end
    aud_write = 1'b0;
    wait_frames(10);

    // Keep writing while full across a frame start.
    for (int i = 0; i < 8; i++) begin
      aud_write   = 1'b1;
      aud_write_d = sample_t'(32'h00A0_0000 + i);
      tick();
    end
    ready_hi = 0;
    tgt      = n_starts + 1;
    for (int i = 0; i < FRAME_CLKS + 64; i++) begin
      if (n_starts >= tgt) break;
      aud_write_d = sample_t'(32'h00B0_0000 + i);
      tick();
      if (aud_write_ready) ready_hi++;
    end
    check("full_reached_start", 64'(n_starts), 64'(tgt));
    for (int i = 0; i < 3; i++) begin
      aud_write_d = aud_write_d + sample_t'(1);
      tick();
      if (aud_write_ready) ready_hi++;
    end
    check("ready_pulse_count", 64'(ready_hi), 64'(1));
    aud_write = 1'b0;
    wait_frames(10);

    // Write lands on the frame-start edge with the FIFO empty.
    repeat (FRAME_CLKS - 1) tick();
    aud_write   = 1'b1;
    aud_write_d = sample_t'(32'h0080_0000);
    tgt         = n_starts + 1;
    tick();
    aud_write   = 1'b0;
    check("push_on_start", 64'(n_starts), 64'(tgt));
    wait_frames(2);

    // Reset mid-frame discards the queued sample and restarts the frame.
    push_one(sample_t'(32'h0012_3456));
    repeat (300) tick();
    #2 reset = 1'b0;
    #1;
    check("rst_async", 64'({aud_write_ready, dac_bclk, dac_lrck, dac_data, underflow}), 64'(0));
    repeat (3) tick();
    release_reset();
    wait_frames(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
